pipe_stage_elastic: RTL and testbench

// - Parametrised elastic pipeline register for inter-stage buffering (IF/ID, ID/EX, EX/MEM, MEM/WB).
// - Replaces free-running stage registers; adds valid/ready handshake, flush and a 2-entry skid buffer.
// - Sustains 1 transfer/cycle under backpressure. in_ready is registered, so no combinational ready path.

---
 rtl/pipe_stage_elastic.sv | 125 ++++++++++++
 tb/tb_pipe_stage_elastic.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: valid/ready handshake, 2-entry skid buffer, registered in_ready, flush.
// Optional saturating backpressure counter enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_elastic #(
  parameter int unsigned WIDTH          = 32,
  parameter bit          CLEAR_ON_FLUSH = 1'b1
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int unsigned CNT_W          = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  input  logic             perf_clr_i,
  output logic [CNT_W-1:0] stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StBusy  = 2'b01,
    StFull  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  // Handshake outputs come straight from the state register: no combinational ready path.
  assign out_valid_o = (state_q != StEmpty);
  assign in_ready_o  = (state_q != StFull);
  assign out_data_o  = main_q;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = StEmpty;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d = StBusy;
            main_d  = in_data_i;
          end
        end
        StBusy: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            state_d = StFull;
            skid_d  = in_data_i;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          // in_ready is low here, so only the skid->main move can happen.
          if (out_fire) begin
            state_d = StBusy;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CntOne = 1;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (perf_clr_i) begin
      stall_cnt_d = '0;
    end else if (out_valid_o && !out_ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  state_legal_a: assert property (@(posedge clk) disable iff (reset) state_q != 2'b11);

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Randomised bench for pipe_stage_elastic against a queue-based model (capacity 2).
// Also exercises the stall counter when built with PIPE_STAGE_PERF_EN.
module tb_pipe_stage_elastic;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;

  int unsigned  total = 0;
  int unsigned  bad = 0;
  logic [W-1:0] q[$];
  bit           zero_known = 1'b1;
  bit           last_in_fire = 1'b0;

`ifdef PIPE_STAGE_PERF_EN
  logic         perf_clr = 1'b0;
  logic [15:0]  stall_cnt;
  logic [1:0]   stall_cnt2;
  logic         in_ready2, out_valid2;
  logic [W-1:0] out_data2;
  int unsigned  cnt_m = 0;
  int unsigned  cnt2_m = 0;
`endif

  always #5 clk = ~clk;

  pipe_stage_elastic #(
    .WIDTH          (W),
    .CLEAR_ON_FLUSH (1'b1)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .CNT_W          (16)
`endif
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_clr_i  (perf_clr),
    .stall_cnt_o (stall_cnt)
`endif
  );

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_elastic #(
    .WIDTH          (W),
    .CLEAR_ON_FLUSH (1'b1),
    .CNT_W          (2)
  ) u_dut_sat (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready2),
    .in_data_i   (in_data),
    .out_valid_o (out_valid2),
    .out_ready_i (out_ready),
    .out_data_o  (out_data2),
    .perf_clr_i  (perf_clr),
    .stall_cnt_o (stall_cnt2)
  );
`endif

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    zero_known   = 1'b1;
    last_in_fire = 1'b1;
`ifdef PIPE_STAGE_PERF_EN
    cnt_m  = 0;
    cnt2_m = 0;
`endif
  endtask

  // One clock: check outputs mid-cycle, then advance the model on the rising edge.
  task automatic tick();
    bit in_fire, out_fire, stall;
    @(negedge clk);
    check_eq("out_valid", out_valid, q.size() > 0);
    check_eq("in_ready", in_ready, q.size() < 2);
    if (q.size() > 0) check_eq("out_data", out_data, q[0]);
    else if (zero_known) check_eq("out_data_zero", out_data, '0);
`ifdef PIPE_STAGE_PERF_EN
    check_eq("stall_cnt", stall_cnt, cnt_m);
    check_eq("stall_cnt_sat", stall_cnt2, cnt2_m);
`endif
    in_fire  = in_valid && (q.size() < 2);
    out_fire = (q.size() > 0) && out_ready;
    stall    = (q.size() > 0) && !out_ready;
    @(posedge clk);
    if (flush) begin
      q.delete();
      zero_known = 1'b1;
    end else begin
      if (out_fire) void'(q.pop_front());
      if (in_fire) begin
        q.push_back(in_data);
        zero_known = 1'b0;
      end
    end
`ifdef PIPE_STAGE_PERF_EN
    if (perf_clr) begin
      cnt_m  = 0;
      cnt2_m = 0;
    end else if (stall) begin
      if (cnt_m < 65535) cnt_m++;
      if (cnt2_m < 3) cnt2_m++;
    end
`endif
    last_in_fire = in_fire || flush;
    #1;
  endtask

  initial begin
    // Reset values
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_out_data", out_data, '0);
`ifdef PIPE_STAGE_PERF_EN
    check_eq("rst_stall_cnt", stall_cnt, '0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();

    // Streaming 1..100 with no backpressure
    out_ready = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();

    // Backpressure: A, B held, then released in order
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAAAA_0001;
    tick();
    in_data   = 32'hBBBB_0002;
    tick();
    in_valid  = 1'b0;
    tick();
    check_eq("bp_full_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    repeat (3) tick();
    check_eq("bp_drained_in_ready", in_ready, 1'b1);

    // Flush in FULL with a live input that must be discarded
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h1111_0001;
    tick();
    in_data   = 32'h2222_0002;
    tick();
    in_data   = 32'h0000_DEAD;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq("flush_out_valid", out_valid, 1'b0);
    check_eq("flush_out_data", out_data, '0);
    repeat (3) tick();

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h3333_0003;
    tick();
    in_data   = 32'h4444_0004;
    tick();
    in_valid  = 1'b0;
    #3 reset  = 1'b1;
    #1;
    check_eq("amid_out_valid", out_valid, 1'b0);
    check_eq("amid_in_ready", in_ready, 1'b1);
    check_eq("amid_out_data", out_data, '0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // Random traffic with occasional flush
    for (int n = 0; n < 10000; n++) begin
      if (!(in_valid && !last_in_fire)) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = $urandom;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
`ifdef PIPE_STAGE_PERF_EN
      perf_clr  = ($urandom_range(0, 99) == 0);
`endif
      tick();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();

`ifdef PIPE_STAGE_PERF_EN
    // Counter: clear, hold one entry for 5 stalled cycles, then clear again
    perf_clr  = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h5555_0005;
    tick();
    perf_clr  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (5) tick();
    check_eq("perf_stall5", stall_cnt, 32'd5);
    check_eq("perf_sat3", stall_cnt2, 32'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("perf_flush_keeps", stall_cnt, 32'd6);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    check_eq("perf_clr", stall_cnt, '0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
